// File: rtl/mem1_stage.sv
// First memory pipeline stage: issues one D-cache request per memory instruction, then forwards it to mem_stage.
// Optional alignment checking is enabled by defining M1S_ALIGN_CHECK_EN.
module mem1_stage #(
   parameter int ES_TO_M1_BUS_WD = 150,
   parameter int M1_TO_MS_BUS_WD = 149
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       es_to_m1s_valid,
   input  logic [ES_TO_M1_BUS_WD-1:0] es_to_m1s_bus,
   output logic                       m1s_allowin,
   input  logic                       ms_allowin,
   output logic                       m1s_to_ms_valid,
   output logic [M1_TO_MS_BUS_WD-1:0] m1s_to_ms_bus,
   input  logic                       flush,
   input  logic                       ex_in_pipe,
   output logic                       data_req,
   output logic                       data_wr,
   output logic [3:0]                 data_wstrb,
   output logic [31:0]                data_addr,
   output logic [31:0]                data_wdata,
   input  logic                       data_addr_ok,
   output logic [4:0]                 M1_dest,
   output logic [31:0]                M1_result,
   output logic                       M1_is_load
);

   typedef enum logic {IDLE, SENT} state_t;

   state_t                     state, state_nxt;
   logic                       m1s_valid;
   logic [ES_TO_M1_BUS_WD-1:0] bus_r;

   logic        inst_mfc0;
   logic [31:0] cp0_data;
   logic        ex_in;
   logic        mem_we;
   logic [31:0] rt_value;
   logic [11:0] mem_inst;
   logic        res_from_mem;
   logic        gr_we;
   logic [4:0]  dest;
   logic [31:0] alu_result;
   logic [31:0] pc;

   assign {inst_mfc0, cp0_data, ex_in, mem_we, rt_value, mem_inst,
           res_from_mem, gr_we, dest, alu_result, pc} = bus_r;

   logic [1:0] addr_lo;
   logic       is_mem;
   logic       adel, ades;
   logic       m1s_ex;
   logic       m1s_ready_go;
   logic       m1s_advance;

   assign addr_lo = alu_result[1:0];
   assign is_mem  = |mem_inst;

`ifdef M1S_ALIGN_CHECK_EN
   // lw/sw need word alignment, lh/lhu/sh halfword; byte and lwl/lwr/swl/swr never fault.
   assign adel = (mem_inst[0] && (addr_lo != 2'b00)) || ((mem_inst[4] || mem_inst[5]) && addr_lo[0]);
   assign ades = (mem_inst[1] && (addr_lo != 2'b00)) || (mem_inst[9] && addr_lo[0]);
`else
   assign adel = 1'b0;
   assign ades = 1'b0;
`endif

   assign m1s_ex = ex_in | adel | ades;

   // data_req must not depend on data_addr_ok, so the cache never sees a combinational loop.
   assign data_req = m1s_valid && is_mem && !m1s_ex && !ex_in_pipe && !flush && (state == IDLE);

   assign m1s_ready_go    = !is_mem || m1s_ex || (data_req && data_addr_ok) || (state == SENT);
   assign m1s_allowin     = !m1s_valid || (m1s_ready_go && ms_allowin);
   assign m1s_to_ms_valid = m1s_valid && m1s_ready_go && !flush;
   assign m1s_advance     = m1s_to_ms_valid && ms_allowin;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m1s_valid <= 1'b0;
      end else if (flush) begin
         m1s_valid <= 1'b0;
      end else if (m1s_allowin) begin
         m1s_valid <= es_to_m1s_valid;
      end
   end

   // NOTE: the payload register is reset too, so all outputs are defined zeros out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus_r <= '0;
      end else if (es_to_m1s_valid && m1s_allowin) begin
         bus_r <= es_to_m1s_bus;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (data_req && data_addr_ok && !m1s_advance) state_nxt = SENT;
         SENT:    if (m1s_advance || flush)                     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      data_wstrb = 4'b0000;
      data_wdata = rt_value;
      if (mem_inst[1]) begin
         data_wstrb = 4'b1111;
      end else if (mem_inst[8]) begin
         data_wstrb = 4'b0001 << addr_lo;
         data_wdata = {4{rt_value[7:0]}};
      end else if (mem_inst[9]) begin
         case (addr_lo)
            2'd0:    data_wstrb = 4'b0011;
            2'd2:    data_wstrb = 4'b1100;
            default: data_wstrb = 4'b0000;
         endcase
         data_wdata = {2{rt_value[15:0]}};
      end else if (mem_inst[10]) begin
         data_wstrb = 4'b1111 >> (2'd3 - addr_lo);
         data_wdata = rt_value >> {2'd3 - addr_lo, 3'b000};
      end else if (mem_inst[11]) begin
         data_wstrb = 4'b1111 << addr_lo;
         data_wdata = rt_value << {addr_lo, 3'b000};
      end
   end

   assign data_addr = {alu_result[31:2], 2'b00};
   assign data_wr   = mem_we;

   assign m1s_to_ms_bus = {inst_mfc0, cp0_data, m1s_ex, rt_value, mem_inst,
                           res_from_mem, gr_we, dest, alu_result, pc};

   assign M1_dest    = dest & {5{m1s_valid && gr_we}};
   assign M1_result  = inst_mfc0 ? cp0_data : alu_result;
   assign M1_is_load = m1s_valid && res_from_mem;

endmodule

// File: tb/tb_mem1_stage.sv
// Scoreboard bench for mem1_stage: expected requests and output payloads are queued at drive time
// and compared when the DUT issues an accepted request or advances an instruction.
module tb_mem1_stage;

   localparam logic [11:0] MI_LW  = 12'h001;
   localparam logic [11:0] MI_SW  = 12'h002;
   localparam logic [11:0] MI_LB  = 12'h004;
   localparam logic [11:0] MI_LH  = 12'h010;
   localparam logic [11:0] MI_SB  = 12'h100;
   localparam logic [11:0] MI_SH  = 12'h200;
   localparam logic [11:0] MI_SWL = 12'h400;
   localparam logic [11:0] MI_SWR = 12'h800;
   localparam logic [11:0] ST_MSK = 12'hF02;

`ifdef M1S_ALIGN_CHECK_EN
   localparam logic ALIGN = 1'b1;
`else
   localparam logic ALIGN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         es_to_m1s_valid;
   logic [149:0] es_to_m1s_bus;
   logic         m1s_allowin;
   logic         ms_allowin;
   logic         m1s_to_ms_valid;
   logic [148:0] m1s_to_ms_bus;
   logic         flush;
   logic         ex_in_pipe;
   logic         data_req;
   logic         data_wr;
   logic [3:0]   data_wstrb;
   logic [31:0]  data_addr;
   logic [31:0]  data_wdata;
   logic         data_addr_ok;
   logic [4:0]   M1_dest;
   logic [31:0]  M1_result;
   logic         M1_is_load;

   always #5 clk = ~clk;

   mem1_stage dut (
      .clk             (clk),
      .reset           (reset),
      .es_to_m1s_valid (es_to_m1s_valid),
      .es_to_m1s_bus   (es_to_m1s_bus),
      .m1s_allowin     (m1s_allowin),
      .ms_allowin      (ms_allowin),
      .m1s_to_ms_valid (m1s_to_ms_valid),
      .m1s_to_ms_bus   (m1s_to_ms_bus),
      .flush           (flush),
      .ex_in_pipe      (ex_in_pipe),
      .data_req        (data_req),
      .data_wr         (data_wr),
      .data_wstrb      (data_wstrb),
      .data_addr       (data_addr),
      .data_wdata      (data_wdata),
      .data_addr_ok    (data_addr_ok),
      .M1_dest         (M1_dest),
      .M1_result       (M1_result),
      .M1_is_load      (M1_is_load)
   );

   typedef struct {
      logic        wr;
      logic [3:0]  strb;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk_wd;
   } req_t;

   typedef struct {
      logic [11:0] mi;
      logic [31:0] addr;
      logic [31:0] rt;
      int          lat;
      logic        ex_in;
      logic        req;
      logic [3:0]  strb;
      logic [31:0] wdata;
      logic        ex_out;
   } case_t;

   req_t         req_q[$];
   logic [148:0] exp_q[$];
   int           n_cmp = 0;
   int           n_bad = 0;
   int           ok_lat = 0;
   int           wait_cnt = 0;
   int           req_hi = 0;
   int           acc_cnt = 0;
   case_t        cases[13];

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [149:0] mk_bus(input logic mfc0, input logic [31:0] cp0, input logic ex,
                                           input logic [31:0] rt, input logic [11:0] mi, input logic [4:0] dst,
                                           input logic gwe, input logic [31:0] alu, input logic [31:0] pc);
      logic we, ld;
      we = |(mi & ST_MSK);
      ld = |mi && !we;
      return {mfc0, cp0, ex, we, rt, mi, ld, gwe, dst, alu, pc};
   endfunction

   function automatic logic [148:0] drop_we(input logic [149:0] b, input logic ex);
      return {b[149:117], ex, b[114:0]};
   endfunction

   function automatic case_t mk_case(input logic [11:0] mi, input logic [31:0] addr, input logic [31:0] rt,
                                     input int lat, input logic ex_in, input logic req, input logic [3:0] strb,
                                     input logic [31:0] wdata, input logic ex_out);
      case_t c;
      c.mi = mi; c.addr = addr; c.rt = rt; c.lat = lat; c.ex_in = ex_in;
      c.req = req; c.strb = strb; c.wdata = wdata; c.ex_out = ex_out;
      return c;
   endfunction

   // Cache model: grants the pending request once it has waited ok_lat cycles.
   always @(posedge clk) begin
      #2;
      data_addr_ok = data_req && (wait_cnt >= ok_lat);
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (data_req) req_hi++;
         if (data_req && data_addr_ok) begin
            req_t r;
            acc_cnt++;
            check("acc_fwd", m1s_to_ms_valid, 1'b1);
            check("req_q_nonempty", req_q.size() != 0, 1'b1);
            if (req_q.size() != 0) begin
               r = req_q.pop_front();
               check("req_wr", data_wr, r.wr);
               check("req_strb", data_wstrb, r.strb);
               check("req_addr", data_addr, r.addr);
               if (r.chk_wd) check("req_wdata", data_wdata, r.wdata);
            end
         end
         if (m1s_to_ms_valid && ms_allowin) begin
            check("out_q_nonempty", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("out_bus", m1s_to_ms_bus, exp_q.pop_front());
         end
      end
      if (data_req && data_addr_ok) wait_cnt = 0;
      else if (data_req)            wait_cnt++;
      else                          wait_cnt = 0;
   end

   task automatic send(input logic [149:0] b);
      int   n;
      logic acc;
      n   = 0;
      acc = 1'b0;
      es_to_m1s_valid = 1'b1;
      es_to_m1s_bus   = b;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = m1s_allowin;
         @(posedge clk);
         #1;
         n++;
      end
      es_to_m1s_valid = 1'b0;
      check("send_accept", acc, 1'b1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || req_q.size() != 0) && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain", exp_q.size() + req_q.size(), 0);
   endtask

   task automatic run_case(input case_t c, input int idx);
      logic [149:0] b;
      logic         st;
      req_t         r;
      st = |(c.mi & ST_MSK);
      b  = mk_bus(1'b0, 32'h0, c.ex_in, c.rt, c.mi, 5'(idx + 1), |c.mi && !st,
                  c.addr, 32'hBFC0_0000 + 32'(idx * 4));
      exp_q.push_back(drop_we(b, c.ex_out));
      if (c.req) begin
         r.wr = st; r.strb = c.strb; r.addr = {c.addr[31:2], 2'b00}; r.wdata = c.wdata; r.chk_wd = st;
         req_q.push_back(r);
      end
      ok_lat = c.lat;
      send(b);
      if (!c.req) check("no_req_fwd", {data_req, m1s_to_ms_valid}, 2'b01);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [149:0] b;
      req_t         r;

      reset = 1'b1; es_to_m1s_valid = 1'b0; es_to_m1s_bus = '0; ms_allowin = 1'b1;
      flush = 1'b0; ex_in_pipe = 1'b0; data_addr_ok = 1'b0;

      cases[0]  = mk_case(MI_LW,  32'h8000_0004, 32'h0,         2, 1'b0, 1'b1,   4'b0000, 32'h0,         1'b0);
      cases[1]  = mk_case(MI_SB,  32'h1000_0003, 32'h0000_00AB, 1, 1'b0, 1'b1,   4'b1000, 32'hABAB_ABAB, 1'b0);
      cases[2]  = mk_case(MI_LH,  32'h1000_0001, 32'h0,         0, 1'b0, !ALIGN, 4'b0000, 32'h0,         ALIGN);
      cases[3]  = mk_case(MI_SWL, 32'h1000_0001, 32'h1122_3344, 0, 1'b0, 1'b1,   4'b0011, 32'h0000_1122, 1'b0);
      cases[4]  = mk_case(MI_SW,  32'h2000_0008, 32'hDEAD_BEEF, 1, 1'b0, 1'b1,   4'b1111, 32'hDEAD_BEEF, 1'b0);
      cases[5]  = mk_case(MI_SH,  32'h2000_0002, 32'h0000_5678, 0, 1'b0, 1'b1,   4'b1100, 32'h5678_5678, 1'b0);
      cases[6]  = mk_case(MI_SWR, 32'h2000_0003, 32'h1122_3344, 3, 1'b0, 1'b1,   4'b1000, 32'h4400_0000, 1'b0);
      cases[7]  = mk_case(MI_SWR, 32'h2000_0001, 32'h1122_3344, 0, 1'b0, 1'b1,   4'b1110, 32'h2233_4400, 1'b0);
      cases[8]  = mk_case(MI_SWL, 32'h2000_0003, 32'h1122_3344, 0, 1'b0, 1'b1,   4'b1111, 32'h1122_3344, 1'b0);
      cases[9]  = mk_case(MI_SW,  32'h2000_0001, 32'hCAFE_F00D, 0, 1'b0, !ALIGN, 4'b1111, 32'hCAFE_F00D, ALIGN);
      cases[10] = mk_case(MI_LW,  32'h3000_0000, 32'h0,         0, 1'b1, 1'b0,   4'b0000, 32'h0,         1'b1);
      cases[11] = mk_case(MI_LB,  32'h3000_0002, 32'h0,         1, 1'b0, 1'b1,   4'b0000, 32'h0,         1'b0);
      cases[12] = mk_case(12'h0,  32'h0000_1234, 32'h5555_5555, 0, 1'b0, 1'b0,   4'b0000, 32'h0,         1'b0);

      repeat (2) @(posedge clk);
      #1;
      check("rst_allowin", m1s_allowin, 1'b1);
      check("rst_ctl", {m1s_to_ms_valid, data_req, data_wr, data_wstrb, M1_is_load}, 8'h00);
      check("rst_data", {data_addr, data_wdata, M1_result, M1_dest}, 101'h0);
      check("rst_bus", m1s_to_ms_bus, 149'h0);
      reset = 1'b0;

      // Bypass from a non-memory mfc0 instruction.
      b = mk_bus(1'b1, 32'h1234_5678, 1'b0, 32'h0, 12'h0, 5'd7, 1'b1, 32'h0000_AAAA, 32'hBFC0_1000);
      exp_q.push_back(drop_we(b, 1'b0));
      send(b);
      check("byp_dest", M1_dest, 5'd7);
      check("byp_result", M1_result, 32'h1234_5678);
      check("byp_is_load", M1_is_load, 1'b0);
      wait_idle();

      for (int i = 0; i < 13; i++) begin
         req_hi = 0;
         run_case(cases[i], i);
         wait_idle();
         if (i == 0) check("lw_req_cycles", req_hi, 3);
      end

      // Accepted but downstream stalled.
      ms_allowin = 1'b0;
      acc_cnt    = 0;
      ok_lat     = 0;
      b = mk_bus(1'b0, 32'h0, 1'b0, 32'h0, MI_LW, 5'd9, 1'b1, 32'h4000_0010, 32'hBFC0_2000);
      exp_q.push_back(drop_we(b, 1'b0));
      r.wr = 1'b0; r.strb = 4'b0000; r.addr = 32'h4000_0010; r.wdata = 32'h0; r.chk_wd = 1'b0;
      req_q.push_back(r);
      send(b);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("stall_ctl", {data_req, m1s_allowin, m1s_to_ms_valid, M1_is_load}, 4'b0011);
         check("stall_dest", M1_dest, 5'd9);
      end
      check("stall_one_accept", acc_cnt, 1);
      ms_allowin = 1'b1;
      wait_idle();

      // ex_in_pipe delays issue only.
      ex_in_pipe = 1'b1;
      run_case(mk_case(MI_SW, 32'h5000_0004, 32'h0BAD_F00D, 0, 1'b0, 1'b1, 4'b1111, 32'h0BAD_F00D, 1'b0), 20);
      for (int i = 0; i < 3; i++) begin
         check("exp_hold", {data_req, m1s_allowin}, 2'b00);
         @(posedge clk);
         #1;
      end
      ex_in_pipe = 1'b0;
      wait_idle();

      // Flush while the request is still pending.
      ok_lat = 100;
      b = mk_bus(1'b0, 32'h0, 1'b0, 32'h0, MI_LW, 5'd3, 1'b1, 32'h6000_0000, 32'hBFC0_3000);
      send(b);
      check("fl_pending_req", data_req, 1'b1);
      flush = 1'b1;
      #1;
      check("fl_req_drop", {data_req, m1s_to_ms_valid}, 2'b00);
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("fl_dropped", {m1s_allowin, M1_is_load, data_req}, 3'b100);

      // Flush while SENT.
      ms_allowin = 1'b0;
      ok_lat     = 0;
      b = mk_bus(1'b0, 32'h0, 1'b0, 32'h0, MI_LW, 5'd4, 1'b1, 32'h6000_0008, 32'hBFC0_3004);
      r.wr = 1'b0; r.strb = 4'b0000; r.addr = 32'h6000_0008; r.wdata = 32'h0; r.chk_wd = 1'b0;
      req_q.push_back(r);
      send(b);
      @(posedge clk);
      #1;
      check("sent_hold", {data_req, m1s_allowin}, 2'b00);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush      = 1'b0;
      ms_allowin = 1'b1;
      check("sent_flushed", {m1s_allowin, m1s_to_ms_valid, M1_is_load}, 3'b100);
      wait_idle();
      run_case(cases[4], 30);
      wait_idle();

      // Asynchronous reset mid-request.
      ok_lat = 100;
      b = mk_bus(1'b0, 32'h0, 1'b0, 32'h0, MI_LW, 5'd5, 1'b1, 32'h7000_0000, 32'hBFC0_4000);
      send(b);
      check("rst_mid_req", data_req, 1'b1);
      #1;
      reset = 1'b1;
      #1;
      check("rst_mid_clear", {data_req, m1s_allowin, m1s_to_ms_valid}, 3'b010);
      @(posedge clk);
      #1;
      reset = 1'b0;
      ok_lat = 0;
      run_case(cases[5], 40);
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
